fifo_rr_arbiter: RTL and testbench
==================================

FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

Interface
REQ-001 SHALL have parameter n_req, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter width, default 8, data bits per entry.
REQ-003 SHALL have parameter depth, default 10, shared FIFO entries (any value >= 2, not restricted to powers of 2).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  n_req  per-requester request.
REQ-007 SHALL have port req_data  input  n_req*width  requester i data at bits [i*width +: width].
REQ-008 SHALL have port req_ready  output  n_req  one-hot or zero grant; a push occurs for requester i when req_valid[i] and req_ready[i].
REQ-009 SHALL have port out_valid  output  1  FIFO head valid, equal to not empty.
REQ-010 SHALL have port out_ready  input  1  consumer accepts head.
REQ-011 SHALL have port out_data  output  width  data at FIFO head.
REQ-012 SHALL have port out_id  output  $clog2(n_req)  index of the requester that wrote the head entry.
REQ-013 SHALL have ports empty and full  output  1 each  registered status flags.
REQ-014 SHALL have port count  output  $clog2(depth+1)  registered occupancy.

Function
REQ-015 SHALL store {id, data} per entry in a depth-entry circular buffer with write and read pointers that wrap from depth-1 to 0.
REQ-016 SHALL compute grant combinationally: none when full=1; otherwise the first asserted req_valid searching upward, with wrap, from last_grant+1.
REQ-017 SHALL assert req_ready only on the granted bit and SHALL NOT assert req_ready on a bit whose req_valid is 0.
REQ-018 SHALL set push = |(req_valid & req_ready) and write entry {grant index, granted data} at the write pointer on that edge.
REQ-019 SHALL set pop = out_valid & out_ready and advance the read pointer on that edge.
REQ-020 SHALL update last_grant to the granted index only on a cycle with push; otherwise it holds.
REQ-021 SHALL drive out_data/out_id from the entry at the read pointer with zero-cycle latency; a pushed entry is visible at the head the cycle after the push.
REQ-022 SHALL update count: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-023 SHALL register empty_next = (count_next == 0) and full_next = (count_next == depth), mutually exclusive.
REQ-024 SHALL block push while full=1 even if pop occurs that cycle; the freed slot is grantable the following cycle.
REQ-025 SHALL, when empty=1, ignore out_ready (no pop); push into an empty FIFO never bypasses to the output.
REQ-026 SHALL, with push and pop in the same cycle while not full and not empty, write and read different or same-indexed slots correctly, with count and flags unchanged.
REQ-027 SHALL present stable out_data/out_id while out_valid=1 and out_ready=0.

Reset
REQ-028 SHALL, on rst=1, asynchronously clear pointers to 0, count to 0, empty to 1, full to 0, last_grant to n_req-1; outputs: out_valid=0, req_ready=0 until the next evaluation after rst release (requester 0 has first priority).
REQ-029 SHALL discard all stored entries on reset mid-operation; buffer contents need not be cleared, and out_data/out_id are don't-care while empty.

Configuration
REQ-030 SHALL, when macro FIFO_RR_ARBITER_FIXED_PRIO_EN is defined, grant the lowest-indexed asserted req_valid regardless of last_grant (last_grant logic removed).
REQ-031 SHALL, when FIFO_RR_ARBITER_FIXED_PRIO_EN is undefined, implement round-robin per REQ-016/REQ-020.

Verification
REQ-032 SHALL cover: all four requesters continuously valid, out_ready=1 -> grants 0,1,2,3,0,...; out_id sequence is identical, offset by 1 cycle.
REQ-033 SHALL cover: out_ready=0, req_valid[2]=1 for 12 cycles with data 0x00..0x0B -> 10 pushes, full=1 and count=10 after the 10th, req_ready=0 afterwards, empty=0.
REQ-034 SHALL cover: full FIFO, out_ready=1 and req_valid=4'b1111 in the same cycle -> no push that cycle, count=9, push next cycle, count back to 10.
REQ-035 SHALL cover: depth=10 with 25 push/pop pairs -> pointers wrap twice; read data matches FIFO order; count stays constant.
REQ-036 SHALL cover: rst pulsed with count=5 between edges -> count=0, empty=1, full=0 immediately; first grant afterwards goes to requester 0.
REQ-037 SHALL cover: FIFO_RR_ARBITER_FIXED_PRIO_EN defined, req_valid=4'b0110 held -> requester 1 granted every cycle, requester 2 never.

Source files
------------

// File: rtl/fifo_rr_arbiter.sv
// Shared FIFO fed by n_req requesters through a round-robin grant; each entry carries {id, data}.
// Define FIFO_RR_ARBITER_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module fifo_rr_arbiter #(
  parameter int n_req = 4,
  parameter int width = 8,
  parameter int depth = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [n_req-1:0]           req_valid,
  input  logic [n_req*width-1:0]     req_data,
  output logic [n_req-1:0]           req_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [width-1:0]           out_data,
  output logic [$clog2(n_req)-1:0]   out_id,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(depth+1)-1:0] count
);

  localparam int id_w  = $clog2(n_req);
  localparam int ptr_w = $clog2(depth);
  localparam int cnt_w = $clog2(depth + 1);
  localparam logic [ptr_w-1:0] last_ptr  = ptr_w'(depth - 1);
  localparam logic [cnt_w-1:0] depth_cnt = cnt_w'(depth);

  logic [id_w+width-1:0] mem_r [depth];
  logic [ptr_w-1:0]      wr_ptr_r;
  logic [ptr_w-1:0]      rd_ptr_r;
  logic [cnt_w-1:0]      count_r;
  logic [cnt_w-1:0]      count_next_s;
  logic                  empty_r;
  logic                  full_r;
  logic [n_req-1:0]      pick_s;
  logic                  grant_any_s;
  logic [id_w-1:0]       grant_idx_s;
  logic [width-1:0]      grant_data_s;
  logic                  push_s;
  logic                  pop_s;
  logic [id_w+width-1:0] head_s;

  function automatic logic [id_w-1:0] lowest_set(input logic [n_req-1:0] v);
    logic [id_w-1:0] idx;
    idx = '0;
    for (int i = n_req - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = id_w'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == last_ptr) ? '0 : p + ptr_w'(1);
  endfunction

`ifdef FIFO_RR_ARBITER_FIXED_PRIO_EN
  assign pick_s = req_valid;
`else
  logic [id_w-1:0]  last_grant_r;
  logic [n_req-1:0] above_mask_s;
  logic [n_req-1:0] hi_req_s;

  // Requesters strictly above last_grant win first; otherwise wrap to the lowest asserted.
  assign above_mask_s = ~((n_req'(2) << last_grant_r) - n_req'(1));
  assign hi_req_s     = req_valid & above_mask_s;
  assign pick_s       = (|hi_req_s) ? hi_req_s : req_valid;

  // Grant pointer moves only when a push actually happens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r <= id_w'(n_req - 1);
    end else if (push_s) begin
      last_grant_r <= grant_idx_s;
    end
  end
`endif

  assign grant_any_s  = (|req_valid) & ~full_r & ~rst;
  assign grant_idx_s  = lowest_set(pick_s);
  assign grant_data_s = req_data[grant_idx_s*width +: width];
  assign req_ready    = grant_any_s ? (n_req'(1) << grant_idx_s) : '0;

  assign push_s = |(req_valid & req_ready);
  assign pop_s  = ~empty_r & out_ready;

  // Occupancy update: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + cnt_w'(1);
      2'b01:   count_next_s = count_r - cnt_w'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Pointers, count and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_next_s;
      empty_r <= (count_next_s == '0);
      full_r  <= (count_next_s == depth_cnt);
    end
  end

  // Entry storage; contents are meaningless while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {grant_idx_s, grant_data_s};
    end
  end

  assign head_s    = mem_r[rd_ptr_r];
  assign out_data  = head_s[width-1:0];
  assign out_id    = head_s[width +: id_w];
  assign out_valid = ~empty_r;
  assign empty     = empty_r;
  assign full      = full_r;
  assign count     = count_r;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed self-checking bench for fifo_rr_arbiter (default parameters, either priority build).
module tb_fifo_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_id;
  logic        empty;
  logic        full;
  logic [3:0]  count;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] q[$];
  logic [15:0] head_v;
  logic [3:0]  exp_ready;
  logic [1:0]  exp_id;

  fifo_rr_arbiter #(.n_req(4), .width(8), .depth(10)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id), .empty(empty), .full(full), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'hF;
    out_ready = 1'b0;
    req_data  = {8'h33, 8'h32, 8'h31, 8'h30};
    #12;
    check_eq("rst_empty", empty, 1'b1);
    check_eq("rst_full", full, 1'b0);
    check_eq("rst_count", count, 4'd0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_req_ready", req_ready, 4'b0000);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;

    // All four requesters valid, consumer always ready.
    for (int k = 0; k < 8; k++) begin
`ifdef FIFO_RR_ARBITER_FIXED_PRIO_EN
      exp_id = 2'd0;
`else
      exp_id = 2'(k % 4);
`endif
      exp_ready = 4'b0001 << exp_id;
      check_eq("rr_grant", req_ready, exp_ready);
      tick();
      check_eq("rr_out_id", out_id, exp_id);
      check_eq("rr_out_data", out_data, 8'h30 + 8'(exp_id));
      check_eq("rr_count", count, 4'd1);
    end
    req_valid = 4'b0000;
    tick();
    check_eq("drain_empty", empty, 1'b1);

    // Fill from requester 2 while the consumer stalls.
    out_ready = 1'b0;
    req_valid = 4'b0100;
    for (int k = 0; k < 12; k++) begin
      req_data = {8'h33, 8'(k), 8'h31, 8'h30};
      #1;
      check_eq("fill_ready", req_ready, (k < 10) ? 4'b0100 : 4'b0000);
      if (k < 10) q.push_back({8'd2, 8'(k)});
      tick();
      check_eq("fill_count", count, (k < 10) ? 4'(k + 1) : 4'd10);
      check_eq("fill_head_stable", out_data, 8'h00);
    end
    check_eq("fill_full", full, 1'b1);
    check_eq("fill_empty", empty, 1'b0);
    check_eq("fill_out_id", out_id, 2'd2);

    // Full with pop and all requesters valid: no push this cycle.
    req_data  = {8'h33, 8'h32, 8'h31, 8'h30};
    req_valid = 4'b1111;
    out_ready = 1'b1;
    #1;
    check_eq("full_no_grant", req_ready, 4'b0000);
    tick();
    void'(q.pop_front());
    check_eq("full_pop_count", count, 4'd9);
    check_eq("full_pop_flag", full, 1'b0);
    out_ready = 1'b0;
    #1;
`ifdef FIFO_RR_ARBITER_FIXED_PRIO_EN
    check_eq("refill_grant", req_ready, 4'b0001);
    q.push_back({8'd0, 8'h30});
`else
    check_eq("refill_grant", req_ready, 4'b1000);
    q.push_back({8'd3, 8'h33});
`endif
    tick();
    check_eq("refill_count", count, 4'd10);
    check_eq("refill_full", full, 1'b1);

    // Drain in FIFO order, then an extra cycle with out_ready on an empty FIFO.
    req_valid = 4'b0000;
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 10; k++) begin
      head_v = q.pop_front();
      check_eq("drain_valid", out_valid, 1'b1);
      check_eq("drain_data", out_data, head_v[7:0]);
      check_eq("drain_id", out_id, head_v[9:8]);
      tick();
    end
    check_eq("drained_empty", empty, 1'b1);
    tick();
    check_eq("empty_no_pop", count, 4'd0);
    check_eq("empty_out_valid", out_valid, 1'b0);

    // Preload 5 entries from requester 1, first push must not bypass.
    out_ready = 1'b0;
    req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      req_data = {8'h33, 8'h32, 8'h40 + 8'(k), 8'h30};
      #1;
      if (k == 0) check_eq("no_bypass", out_valid, 1'b0);
      q.push_back({8'd1, 8'h40 + 8'(k)});
      tick();
    end
    check_eq("preload_count", count, 4'd5);

    // 25 simultaneous push/pop pairs wrap both pointers.
    out_ready = 1'b1;
    for (int k = 0; k < 25; k++) begin
      req_data = {8'h33, 8'h32, 8'h50 + 8'(k), 8'h30};
      #1;
      head_v = q.pop_front();
      check_eq("pair_ready", req_ready, 4'b0010);
      check_eq("pair_data", out_data, head_v[7:0]);
      check_eq("pair_id", out_id, head_v[9:8]);
      q.push_back({8'd1, 8'h50 + 8'(k)});
      tick();
      check_eq("pair_count", count, 4'd5);
    end
    check_eq("pair_full", full, 1'b0);

    // Asynchronous reset between edges with count=5.
    out_ready = 1'b0;
    req_valid = 4'b0000;
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_count", count, 4'd0);
    check_eq("arst_empty", empty, 1'b1);
    check_eq("arst_full", full, 1'b0);
    check_eq("arst_out_valid", out_valid, 1'b0);
    #1;
    rst = 1'b0;
    req_valid = 4'b1111;
    req_data  = {8'h33, 8'h32, 8'h31, 8'h30};
    #1;
    check_eq("arst_first_grant", req_ready, 4'b0001);
    tick();
    check_eq("arst_push_count", count, 4'd1);
    check_eq("arst_push_id", out_id, 2'd0);

    // Requesters 1 and 2 held valid.
    req_valid = 4'b0110;
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
`ifdef FIFO_RR_ARBITER_FIXED_PRIO_EN
      exp_ready = 4'b0010;
`else
      exp_ready = (k % 2 == 0) ? 4'b0010 : 4'b0100;
`endif
      check_eq("pair12_grant", req_ready, exp_ready);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
